// File: rtl/ysyx_25030085_callstack_chk.sv
// ysyx_25030085_callstack_chk: shadow return-address stack that checks every return against recorded calls.
// Returns are checked in CHECK against the top entry, then walked down one entry per cycle in UNWIND.
module ysyx_25030085_callstack_chk #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ev_valid,
    output logic          ev_ready,
    input  logic [1:0]    ev_type,
    input  logic [31:0]   ev_pc,
    input  logic [31:0]   ev_dnpc,
    input  logic          clr,
    output logic [AW:0]   depth,
    output logic          ret_ok,
    output logic          ret_unwound,
    output logic          mismatch,
    output logic [31:0]   mis_exp,
    output logic [31:0]   mis_got,
    output logic          overflow,
    output logic          underflow,
    output logic [15:0]   err_count
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CHECK  = 2'd1;
    localparam logic [1:0] S_UNWIND = 2'd2;

    logic [1:0]    r_state;
    logic [31:0]   r_stk [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_probe;
    logic [AW:0]   r_depth;
    logic [AW:0]   r_pidx;
    logic [31:0]   r_tgt;
    logic          r_ok, r_unw, r_mis;
    logic [31:0]   r_mis_exp, r_mis_got;
    logic          r_ovf, r_udf;
    logic [15:0]   r_err;

    logic [AW-1:0] w_top_ptr;
    logic [31:0]   w_top;
    logic          w_call, w_ret, w_full, w_empty;
    logic          w_hit_top, w_hit_probe, w_udf_ev, w_mis_ev;

    assign ev_ready    = r_state == S_IDLE;
    assign w_top_ptr   = r_wp - 1'b1;
    assign w_top       = r_stk[w_top_ptr];
    assign w_call      = ev_valid && ev_ready && ev_type == 2'b01;
    assign w_ret       = ev_valid && ev_ready && ev_type == 2'b10;
    assign w_full      = r_depth == (AW+1)'(DEPTH);
    assign w_empty     = r_depth == '0;
    assign w_hit_top   = w_top == r_tgt;
    assign w_hit_probe = r_stk[r_probe] == r_tgt;
    assign w_udf_ev    = w_ret && w_empty;
    assign w_mis_ev    = (r_state == S_CHECK && !w_hit_top && r_depth == (AW+1)'(1)) ||
                         (r_state == S_UNWIND && !w_hit_probe && r_pidx == '0);

    // When full, r_wp already points at the oldest entry, so a push overwrites it.
    always_ff @(posedge clk) begin
        if (w_call) r_stk[r_wp] <= ev_pc + 32'd4;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_wp      <= '0;
            r_probe   <= '0;
            r_depth   <= '0;
            r_pidx    <= '0;
            r_tgt     <= '0;
            r_ok      <= 1'b0;
            r_unw     <= 1'b0;
            r_mis     <= 1'b0;
            r_mis_exp <= '0;
            r_mis_got <= '0;
        end else begin
            r_ok  <= 1'b0;
            r_unw <= 1'b0;
            r_mis <= w_mis_ev;
            if (w_mis_ev) begin
                r_mis_exp <= w_top;
                r_mis_got <= r_tgt;
                r_state   <= S_IDLE;
            end
            if (r_state == S_IDLE) begin
                if (w_call) begin
                    r_wp    <= r_wp + 1'b1;
                    r_depth <= w_full ? r_depth : r_depth + 1'b1;
                end
                if (w_ret && !w_empty) begin
                    r_tgt   <= ev_dnpc;
                    r_state <= S_CHECK;
                end
            end else if (r_state == S_CHECK) begin
                if (w_hit_top) begin
                    r_wp    <= w_top_ptr;
                    r_depth <= r_depth - 1'b1;
                    r_ok    <= 1'b1;
                    r_state <= S_IDLE;
                end else if (!w_mis_ev) begin
                    r_probe <= r_wp - AW'(2);
                    r_pidx  <= r_depth - (AW+1)'(2);
                    r_state <= S_UNWIND;
                end
            end else if (r_state == S_UNWIND) begin
                if (w_hit_probe) begin
                    r_wp    <= r_probe;
                    r_depth <= r_pidx;
                    r_unw   <= 1'b1;
                    r_state <= S_IDLE;
                end else if (!w_mis_ev) begin
                    r_probe <= r_probe - 1'b1;
                    r_pidx  <= r_pidx - 1'b1;
                end
            end else begin
                r_state <= S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
            r_err <= '0;
        end else if (clr) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
            r_err <= '0;
        end else begin
            r_ovf <= r_ovf | (w_call && w_full);
            r_udf <= r_udf | w_udf_ev;
            r_err <= ((w_udf_ev || w_mis_ev) && r_err != 16'hFFFF) ? r_err + 16'd1 : r_err;
        end
    end

    assign depth       = r_depth;
    assign ret_ok      = r_ok;
    assign ret_unwound = r_unw;
    assign mismatch    = r_mis;
    assign mis_exp     = r_mis_exp;
    assign mis_got     = r_mis_got;
    assign overflow    = r_ovf;
    assign underflow   = r_udf;
    assign err_count   = r_err;
endmodule
